// File: rtl/int_entry_sequencer.sv
// int_entry_sequencer: hardware interrupt entry sequencer (drain, push PC/flags, fetch vector, redirect fetch); optional memory timeout via INT_SEQ_TIMEOUT_EN
module int_entry_sequencer #(
  parameter int          DRAIN_CYCLES   = 3,
  parameter logic [15:0] IVT_BASE       = 16'h0000,
  parameter logic [1:0]  PC_SEL_INT     = 2'b10,
  parameter int          TIMEOUT_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        int_req,
  input  logic [2:0]  int_index,
  input  logic [31:0] cur_pc,
  input  logic [3:0]  flags,
  input  logic        mem_ready,
  input  logic [31:0] ivt_data,
  output logic        busy,
  output logic        stall_fetch,
  output logic        flush_dec,
  output logic        mem_req,
  output logic        mem_write,
  output logic        mem_is_stack,
  output logic        mem_en32,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  pc_select,
  output logic [31:0] new_pc,
  output logic        int_ack,
  output logic        err
);
  typedef enum logic [2:0] {IDLE, DRAIN, PUSH_PC, PUSH_FLG, READ_IVT, LOAD_PC} state_t;
  localparam int CW = $clog2(DRAIN_CYCLES + 1);
  if (DRAIN_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("int_entry_sequencer: DRAIN_CYCLES and TIMEOUT_CYCLES must be >= 1");
  end
  state_t        state, nxt;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [31:0]   saved_pc;
  logic [3:0]    saved_flg;
  logic          xfer, tmo;
  assign xfer = mem_req & mem_ready;
`ifdef INT_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wcnt;
  assign tmo = mem_req & ~mem_ready & (wcnt == TW'(TIMEOUT_CYCLES - 1));
  // wait counter restarts on every state change, counts stalled request cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wcnt <= '0;
    else if (state != nxt) wcnt <= '0;
    else if (mem_req && !mem_ready) wcnt <= wcnt + 1'b1;
  end
`else
  assign tmo = 1'b0;
`endif
  // next-state: memory states advance only on a completed handshake
  always_comb begin
    nxt = state;
    case (state)
      IDLE:     nxt = int_req ? DRAIN : IDLE;
      DRAIN:    nxt = (cnt == '0) ? PUSH_PC : DRAIN;
      PUSH_PC:  nxt = tmo ? IDLE : xfer ? PUSH_FLG : PUSH_PC;
      PUSH_FLG: nxt = tmo ? IDLE : xfer ? READ_IVT : PUSH_FLG;
      READ_IVT: nxt = tmo ? IDLE : xfer ? LOAD_PC : READ_IVT;
      default:  nxt = IDLE;
    endcase
  end
  // state, captured context and outputs registered from the upcoming state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      idx          <= '0;
      saved_pc     <= '0;
      saved_flg    <= '0;
      busy         <= 1'b0;
      stall_fetch  <= 1'b0;
      flush_dec    <= 1'b0;
      mem_req      <= 1'b0;
      mem_write    <= 1'b0;
      mem_is_stack <= 1'b0;
      mem_en32     <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      pc_select    <= '0;
      new_pc       <= '0;
      int_ack      <= 1'b0;
      err          <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE) cnt <= CW'(DRAIN_CYCLES - 1);
      else if (state == DRAIN && cnt != '0) cnt <= cnt - 1'b1;
      if (state == IDLE && int_req) idx <= int_index;
      if (state == DRAIN && cnt == '0) begin
        saved_pc  <= cur_pc;
        saved_flg <= flags;
      end
      if (state == READ_IVT && xfer) new_pc <= ivt_data;
      busy         <= nxt != IDLE;
      stall_fetch  <= nxt inside {DRAIN, PUSH_PC, PUSH_FLG, READ_IVT};
      flush_dec    <= nxt inside {DRAIN, LOAD_PC};
      mem_req      <= nxt inside {PUSH_PC, PUSH_FLG, READ_IVT};
      mem_write    <= nxt inside {PUSH_PC, PUSH_FLG};
      mem_is_stack <= nxt inside {PUSH_PC, PUSH_FLG};
      mem_en32     <= nxt inside {PUSH_PC, READ_IVT};
      mem_addr     <= (nxt == READ_IVT) ? IVT_BASE + {12'b0, idx, 1'b0} : '0;
      mem_wdata    <= (nxt == PUSH_PC) ? ((state == DRAIN) ? cur_pc : saved_pc) :
                      (nxt == PUSH_FLG) ? {28'b0, saved_flg} : '0;
      pc_select    <= (nxt == LOAD_PC) ? PC_SEL_INT : 2'b00;
      int_ack      <= nxt == LOAD_PC;
      err          <= tmo;
    end
  end
endmodule
